eth_tx_arbiter: RTL

//  Packet-granular round-robin arbiter sharing one 10G MAC TX AXI-Stream port between two sources,
//  e.g. the forwarding path and the KVS reply path from eth_encap. Never interleaves beats of two frames.

---
 rtl/eth_tx_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter that merges two AXI-Stream frame sources onto one 10G MAC TX port.
// A source that stalls mid-frame has its frame aborted toward the MAC (tuser=1), and the rest of that frame is flushed.
//
// state | meaning
// IDLE  | no frame owned; choose the next source (one cycle of arbitration)
// SEND  | granted source muxed straight through to the MAC
// ABORT | present one terminating beat with tuser=1 to the MAC
// FLUSH | swallow the remainder of the aborted frame from its source

module eth_tx_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int STALL_MAX  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk156,
    input  logic                  eth_rst,

    input  logic                  s_axis_in0_tvalid,
    output logic                  s_axis_in0_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_in0_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_in0_tkeep,
    input  logic                  s_axis_in0_tlast,
    input  logic                  s_axis_in0_tuser,

    input  logic                  s_axis_in1_tvalid,
    output logic                  s_axis_in1_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_in1_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_in1_tkeep,
    input  logic                  s_axis_in1_tlast,
    input  logic                  s_axis_in1_tuser,

    output logic                  m_axis_tx_tvalid,
    input  logic                  m_axis_tx_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tx_tkeep,
    output logic                  m_axis_tx_tlast,
    output logic                  m_axis_tx_tuser,

    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic [15:0]           abort_cnt,
    output logic [7:0]            debug
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_ABORT = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int SW = (STALL_MAX > 2) ? $clog2(STALL_MAX) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [SW-1:0]         stall_q, stall_d;
    logic [CNT_WIDTH-1:0]  pkt0_q, pkt0_d;
    logic [CNT_WIDTH-1:0]  pkt1_q, pkt1_d;
    logic [15:0]           abort_q, abort_d;

    logic                  g_tvalid;
    logic [DATA_WIDTH-1:0] g_tdata;
    logic [KEEP_WIDTH-1:0] g_tkeep;
    logic                  g_tlast;
    logic                  g_tuser;
    logic                  g_tready;

    assign g_tvalid = grant_q ? s_axis_in1_tvalid : s_axis_in0_tvalid;
    assign g_tdata  = grant_q ? s_axis_in1_tdata  : s_axis_in0_tdata;
    assign g_tkeep  = grant_q ? s_axis_in1_tkeep  : s_axis_in0_tkeep;
    assign g_tlast  = grant_q ? s_axis_in1_tlast  : s_axis_in0_tlast;
    assign g_tuser  = grant_q ? s_axis_in1_tuser  : s_axis_in0_tuser;

    assign s_axis_in0_tready = g_tready & ~grant_q;
    assign s_axis_in1_tready = g_tready &  grant_q;

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        stall_d          = stall_q;
        pkt0_d           = pkt0_q;
        pkt1_d           = pkt1_q;
        abort_d          = abort_q;
        g_tready         = 1'b0;
        m_axis_tx_tvalid = 1'b0;
        m_axis_tx_tdata  = '0;
        m_axis_tx_tkeep  = '0;
        m_axis_tx_tlast  = 1'b0;
        m_axis_tx_tuser  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_axis_in0_tvalid || s_axis_in1_tvalid) begin
                    // Both requesting: the port that did not win last time goes next.
                    if (s_axis_in0_tvalid && s_axis_in1_tvalid) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = s_axis_in1_tvalid;
                    end
                    last_grant_d = grant_d;
                    stall_d      = '0;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                m_axis_tx_tvalid = g_tvalid;
                m_axis_tx_tdata  = g_tdata;
                m_axis_tx_tkeep  = g_tkeep;
                m_axis_tx_tlast  = g_tlast;
                m_axis_tx_tuser  = g_tuser;
                g_tready         = m_axis_tx_tready;
                if (g_tvalid) begin
                    stall_d = '0;
                    if (m_axis_tx_tready && g_tlast) begin
                        if (grant_q) begin
                            pkt1_d = pkt1_q + CNT_WIDTH'(1);
                        end else begin
                            pkt0_d = pkt0_q + CNT_WIDTH'(1);
                        end
                        state_d = ST_IDLE;
                    end
                end else if (stall_q == STALL_LAST) begin
                    state_d = ST_ABORT;
                end else begin
                    stall_d = stall_q + SW'(1);
                end
            end
            ST_ABORT: begin
                m_axis_tx_tvalid = 1'b1;
                m_axis_tx_tkeep  = KEEP_WIDTH'(1);
                m_axis_tx_tlast  = 1'b1;
                m_axis_tx_tuser  = 1'b1;
                if (m_axis_tx_tready) begin
                    if (abort_q != 16'hffff) begin
                        abort_d = abort_q + 16'd1;
                    end
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                g_tready = 1'b1;
                if (g_tvalid && g_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            stall_q      <= '0;
            pkt0_q       <= '0;
            pkt1_q       <= '0;
            abort_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            stall_q      <= stall_d;
            pkt0_q       <= pkt0_d;
            pkt1_q       <= pkt1_d;
            abort_q      <= abort_d;
        end
    end

    assign pkt_cnt0  = pkt0_q;
    assign pkt_cnt1  = pkt1_q;
    assign abort_cnt = abort_q;
    assign debug     = {state_q, grant_q, last_grant_q, 4'b0000};

endmodule
